// File: rtl/ag_pkg.sv
// Shared definitions for the hysteresis actuator controller: per-channel
// state encoding and default timing constants.
package ag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ON_DWELL  = 3'd1,
    ST_ON        = 3'd2,
    ST_OFF_DWELL = 3'd3,
    ST_FAULT     = 3'd4
  } ag_state_e;

  localparam int AG_N_CH_DEF     = 4;
  localparam int AG_SENS_W_DEF   = 4;
  localparam int AG_TICK_DIV_DEF = 25000;  // 1 kHz dwell tick at 25 MHz
  localparam int AG_MIN_ON_DEF   = 4;
  localparam int AG_MIN_OFF_DEF  = 4;
  localparam int AG_MAX_ON_DEF   = 60000;

endpackage

// File: rtl/ag_hyst_channel.sv
// One actuator channel: threshold compare with hysteresis, minimum on/off
// dwell, maximum on-time fault and override handling.
module ag_hyst_channel
  import ag_pkg::*;
#(
  parameter int SENS_W  = AG_SENS_W_DEF,
  parameter int MIN_ON  = AG_MIN_ON_DEF,
  parameter int MIN_OFF = AG_MIN_OFF_DEF,
  parameter int MAX_ON  = AG_MAX_ON_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic              tick_i,
  input  logic [SENS_W-1:0] sensor_i,
  input  logic [SENS_W-1:0] thr_on_i,
  input  logic [SENS_W-1:0] thr_off_i,
  input  logic              dir_i,
  input  logic              override_i,
  input  logic              fault_clr_i,
  output logic              actuator_o,
  output logic              fault_o,
  output logic              cfg_err_o
);

  localparam int CW = $clog2(MAX_ON + 1);
  localparam logic [CW-1:0] MIN_ON_C  = CW'(MIN_ON);
  localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);
  localparam logic [CW-1:0] MAX_ON_C  = CW'(MAX_ON);

  ag_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          cfg_q;
  logic          misconf;
  logic          demand;
  logic          rel;

  // Threshold evaluation; a misconfigured channel is blocked from demand.
  always_comb begin
    misconf = dir_i ? (thr_on_i < thr_off_i) : (thr_on_i > thr_off_i);
    demand  = !misconf && (dir_i ? (sensor_i >= thr_on_i) : (sensor_i <= thr_on_i));
    rel     = dir_i ? (sensor_i <= thr_off_i) : (sensor_i >= thr_off_i);
    cnt_inc = (cnt_q == MAX_ON_C) ? cnt_q : cnt_q + CW'(1);
  end

  // Channel FSM with its dwell counter and registered config-error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cfg_q   <= 1'b0;
    end else if (ena_i) begin
      cfg_q <= misconf;
      unique case (state_q)
        ST_IDLE: begin
          if (demand && !override_i) begin
            state_q <= ST_ON_DWELL;
            cnt_q   <= '0;
          end
        end
        ST_ON_DWELL: begin
          if (override_i) begin
            state_q <= ST_OFF_DWELL;
            cnt_q   <= '0;
          end else if (tick_i) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= MIN_ON_C) state_q <= ST_ON;
          end
        end
        ST_ON: begin
          // Counter keeps running from ON_DWELL entry, so max on-time
          // includes the minimum dwell.
          if (override_i) begin
            state_q <= ST_OFF_DWELL;
            cnt_q   <= '0;
          end else if (cnt_q == MAX_ON_C) begin
            state_q <= ST_FAULT;
          end else if (rel) begin
            state_q <= ST_OFF_DWELL;
            cnt_q   <= '0;
          end else if (tick_i) begin
            cnt_q <= cnt_inc;
          end
        end
        ST_OFF_DWELL: begin
          if (tick_i) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= MIN_OFF_C) state_q <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clr_i) begin
            state_q <= ST_OFF_DWELL;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign actuator_o = (state_q == ST_ON_DWELL) || (state_q == ST_ON);
  assign fault_o    = (state_q == ST_FAULT);
  assign cfg_err_o  = cfg_q;

endmodule

// File: rtl/ag_hysteresis_ctrl.sv
// Multi-channel hysteresis actuator controller: shared dwell-tick
// prescaler, N_CH independent channels and a registered fault summary.
module ag_hysteresis_ctrl
  import ag_pkg::*;
#(
  parameter int N_CH     = AG_N_CH_DEF,
  parameter int SENS_W   = AG_SENS_W_DEF,
  parameter int TICK_DIV = AG_TICK_DIV_DEF,
  parameter int MIN_ON   = AG_MIN_ON_DEF,
  parameter int MIN_OFF  = AG_MIN_OFF_DEF,
  parameter int MAX_ON   = AG_MAX_ON_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [N_CH*SENS_W-1:0]   sensor_in,
  input  logic [N_CH*SENS_W-1:0]   thr_on,
  input  logic [N_CH*SENS_W-1:0]   thr_off,
  input  logic [N_CH-1:0]          dir,
  input  logic                     override,
  input  logic                     fault_clr,
  output logic [N_CH-1:0]          actuator_out,
  output logic [N_CH-1:0]          fault,
  output logic [N_CH-1:0]          cfg_err,
  output logic                     any_fault
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;
  logic          tick;
  logic          any_fault_q;

  assign tick = ena && (pre_q == PRE_LAST);

  // Dwell-tick prescaler; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (ena) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ag_hyst_channel #(
      .SENS_W (SENS_W),
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF),
      .MAX_ON (MAX_ON)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .ena_i      (ena),
      .tick_i     (tick),
      .sensor_i   (sensor_in[g*SENS_W +: SENS_W]),
      .thr_on_i   (thr_on[g*SENS_W +: SENS_W]),
      .thr_off_i  (thr_off[g*SENS_W +: SENS_W]),
      .dir_i      (dir[g]),
      .override_i (override),
      .fault_clr_i(fault_clr),
      .actuator_o (actuator_out[g]),
      .fault_o    (fault[g]),
      .cfg_err_o  (cfg_err[g])
    );
  end

  // Fault summary, one cycle behind the per-channel fault bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_fault_q <= 1'b0;
    end else begin
      any_fault_q <= |fault;
    end
  end

  assign any_fault = any_fault_q;

endmodule

// File: tb/tb_ag_hysteresis_ctrl.sv
// Self-checking bench for ag_hysteresis_ctrl with a time-based reference model.
module tb_ag_hysteresis_ctrl;

  localparam int NC = 2;
  localparam int SW = 4;
  localparam int TD = 4;
  localparam int MON = 2;
  localparam int MOFF = 3;
  localparam int MAXON = 8;

  localparam int P_IDLE = 0, P_WARM = 1, P_RUN = 2, P_COOL = 3, P_FLT = 4;

  logic clk = 1'b0;
  logic rst_n, ena, override, fault_clr;
  logic [NC*SW-1:0] sensor_in, thr_on, thr_off;
  logic [NC-1:0] dir;
  logic [NC-1:0] actuator_out, fault, cfg_err;
  logic any_fault;

  int n_vec, n_err;

  // reference model state: phase, global tick number at phase entry
  int phase [NC];
  int t_start [NC];
  bit mcfg [NC];
  int n_ticks;
  int pre;
  bit manyf;

  ag_hysteresis_ctrl #(
    .N_CH(NC), .SENS_W(SW), .TICK_DIV(TD),
    .MIN_ON(MON), .MIN_OFF(MOFF), .MAX_ON(MAXON)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sensor_in(sensor_in), .thr_on(thr_on), .thr_off(thr_off), .dir(dir),
    .override(override), .fault_clr(fault_clr),
    .actuator_out(actuator_out), .fault(fault), .cfg_err(cfg_err),
    .any_fault(any_fault)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      phase[c] = P_IDLE;
      t_start[c] = 0;
      mcfg[c] = 1'b0;
    end
    pre = 0;
    manyf = 1'b0;
  endtask

  task automatic model_ch(input int c, input bit tk, input int prev);
    int s, on, off, el_now, el_prev;
    bit d, bad, want, done;
    s = int'(sensor_in[c*SW +: SW]);
    on = int'(thr_on[c*SW +: SW]);
    off = int'(thr_off[c*SW +: SW]);
    d = dir[c];
    bad = d ? (on < off) : (on > off);
    want = !bad && (d ? (s >= on) : (s <= on));
    done = d ? (s <= off) : (s >= off);
    el_now = n_ticks - t_start[c];
    el_prev = prev - t_start[c];
    mcfg[c] = bad;
    case (phase[c])
      P_IDLE: if (want && !override) begin phase[c] = P_WARM; t_start[c] = n_ticks; end
      P_WARM: begin
        if (override) begin phase[c] = P_COOL; t_start[c] = n_ticks; end
        else if (tk && el_now >= MON) phase[c] = P_RUN;
      end
      P_RUN: begin
        if (override) begin phase[c] = P_COOL; t_start[c] = n_ticks; end
        else if (el_prev >= MAXON) phase[c] = P_FLT;
        else if (done) begin phase[c] = P_COOL; t_start[c] = n_ticks; end
      end
      P_COOL: if (tk && el_now >= MOFF) phase[c] = P_IDLE;
      P_FLT: if (fault_clr) begin phase[c] = P_COOL; t_start[c] = n_ticks; end
      default: phase[c] = P_IDLE;
    endcase
  endtask

  task automatic model_step();
    bit af, tk;
    int prev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    af = 1'b0;
    for (int c = 0; c < NC; c++) if (phase[c] == P_FLT) af = 1'b1;
    manyf = af;
    if (ena) begin
      tk = (pre == TD - 1);
      prev = n_ticks;
      if (tk) begin n_ticks++; pre = 0; end
      else pre++;
      for (int c = 0; c < NC; c++) model_ch(c, tk, prev);
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0] ea, ef, ec;
    for (int c = 0; c < NC; c++) begin
      ea[c] = (phase[c] == P_WARM) || (phase[c] == P_RUN);
      ef[c] = (phase[c] == P_FLT);
      ec[c] = mcfg[c];
    end
    chk_eq("actuator_out", 32'(actuator_out), 32'(ea));
    chk_eq("fault", 32'(fault), 32'(ef));
    chk_eq("cfg_err", 32'(cfg_err), 32'(ec));
    chk_eq("any_fault", 32'(any_fault), 32'(manyf));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_ch(input int c, input int s, input int on, input int off, input bit d);
    sensor_in[c*SW +: SW] = SW'(s);
    thr_on[c*SW +: SW] = SW'(on);
    thr_off[c*SW +: SW] = SW'(off);
    dir[c] = d;
  endtask

  task automatic set_sens(input int c, input int s);
    sensor_in[c*SW +: SW] = SW'(s);
  endtask

  task automatic wait_fault1(input string tag);
    int k;
    k = 0;
    while (fault[1] !== 1'b1 && k < 80) begin
      step();
      k++;
    end
    chk_eq(tag, 32'(fault[1]), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_ticks = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    override = 1'b0;
    fault_clr = 1'b0;
    sensor_in = '0;
    thr_on = '0;
    thr_off = '0;
    dir = '0;
    set_ch(0, 9, 5, 9, 1'b0);
    set_ch(1, 11, 12, 10, 1'b1);
    model_reset();
    #2;
    compare_all();
    step();
    rst_n = 1'b1;

    // basic on/off with hysteresis on ch0
    set_sens(0, 4);
    step();
    chk_eq("on_after_low", 32'(actuator_out[0]), 32'd1);
    set_sens(0, 7);
    run(16);
    chk_eq("hold_in_band", 32'(actuator_out[0]), 32'd1);
    set_sens(0, 9);
    step();
    chk_eq("off_at_release", 32'(actuator_out[0]), 32'd0);
    run(16);

    // minimum on dwell, then minimum off dwell
    set_sens(0, 4);
    step();
    set_sens(0, 9);
    run(2);
    chk_eq("min_on_hold", 32'(actuator_out[0]), 32'd1);
    run(10);
    chk_eq("min_on_release", 32'(actuator_out[0]), 32'd0);
    set_sens(0, 4);
    run(2);
    chk_eq("min_off_hold", 32'(actuator_out[0]), 32'd0);
    run(16);

    // max on-time fault on ch1
    set_sens(0, 9);
    set_sens(1, 13);
    wait_fault1("fault_reached");
    chk_eq("fault_act_low", 32'(actuator_out[1]), 32'd0);
    step();
    chk_eq("any_fault_late", 32'(any_fault), 32'd1);
    run(16);

    // override during ON_DWELL; FAULT ignores override
    set_sens(0, 4);
    step();
    set_sens(0, 9);
    override = 1'b1;
    step();
    override = 1'b0;
    chk_eq("ovr_act_off", 32'(actuator_out[0]), 32'd0);
    chk_eq("ovr_fault_kept", 32'(fault[1]), 32'd1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk_eq("fault_cleared", 32'(fault[1]), 32'd0);
    run(20);

    // misconfigured channel never actuates
    set_ch(0, 0, 9, 5, 1'b0);
    run(16);
    chk_eq("cfg_err_set", 32'(cfg_err[0]), 32'd1);
    chk_eq("cfg_no_act", 32'(actuator_out[0]), 32'd0);

    // asynchronous reset in the middle of FAULT / ON_DWELL
    set_ch(0, 9, 5, 9, 1'b0);
    wait_fault1("fault_again");
    set_sens(0, 4);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk_eq("rst_any_fault", 32'(any_fault), 32'd0);
    step();
    rst_n = 1'b1;

    // enable low freezes everything
    set_sens(1, 11);
    set_sens(0, 4);
    run(3);
    ena = 1'b0;
    override = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_sens(0, $urandom_range(0, 15));
      step();
    end
    chk_eq("ena_hold_act", 32'(actuator_out[0]), 32'd1);
    ena = 1'b1;
    override = 1'b0;
    set_sens(0, 4);
    run(20);

    // randomized traffic
    for (int seg = 0; seg < 15; seg++) begin
      for (int c = 0; c < NC; c++) begin
        int a, b;
        bit d;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        d = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 85) begin
          if (d == 1'b0) set_ch(c, $urandom_range(0, 15), (a < b) ? a : b, (a < b) ? b : a, d);
          else set_ch(c, $urandom_range(0, 15), (a < b) ? b : a, (a < b) ? a : b, d);
        end else begin
          set_ch(c, $urandom_range(0, 15), a, b, d);
        end
      end
      for (int k = 0; k < 40; k++) begin
        for (int c = 0; c < NC; c++)
          if ($urandom_range(0, 99) < 30) set_sens(c, $urandom_range(0, 15));
        override = ($urandom_range(0, 99) < 2);
        fault_clr = ($urandom_range(0, 99) < 4);
        ena = ($urandom_range(0, 99) >= 5);
        step();
      end
    end
    ena = 1'b1;
    override = 1'b0;
    fault_clr = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
